// File: rtl/raster_scan_sequencer.sv
// Bounding-box raster walker: byte-wise config registers, row-major pixel
// emission over valid/ready, and lockstep strobes for the edge evaluator.
module raster_scan_sequencer #(
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_wr,
    input  logic [1:0]         cfg_addr,
    input  logic [COORD_W-1:0] cfg_data,
    input  logic               start,
    input  logic               abort,
    input  logic               pix_ready,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_last,
    output logic               ee_load,
    output logic               ee_step_x,
    output logic               ee_step_row,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_DONE
    } state_t;

    state_t state;

    logic [COORD_W-1:0] xmin, ymin, xmax, ymax;
    // Box snapshot taken at start, so a same-cycle config write cannot alter
    // the scan that start launches.
    logic [COORD_W-1:0] box_x0, box_y0, box_x1, box_y1;
    logic [COORD_W-1:0] x_inc, y_inc;

    always_comb begin
        x_inc = pix_x + 1'b1;
        y_inc = pix_y + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            xmin        <= '0;
            ymin        <= '0;
            xmax        <= '0;
            ymax        <= '0;
            box_x0      <= '0;
            box_y0      <= '0;
            box_x1      <= '0;
            box_y1      <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_last    <= 1'b0;
            ee_load     <= 1'b0;
            ee_step_x   <= 1'b0;
            ee_step_row <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (state == S_IDLE && cfg_wr) begin
                case (cfg_addr)
                    2'd0: xmin <= cfg_data;
                    2'd1: ymin <= cfg_data;
                    2'd2: xmax <= cfg_data;
                    default: ymax <= cfg_data;
                endcase
            end

            if (abort) begin
                state       <= S_IDLE;
                pix_valid   <= 1'b0;
                pix_last    <= 1'b0;
                ee_load     <= 1'b0;
                ee_step_x   <= 1'b0;
                ee_step_row <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b0;
            end else begin
                ee_load     <= 1'b0;
                ee_step_x   <= 1'b0;
                ee_step_row <= 1'b0;
                done        <= 1'b0;

                case (state)
                    S_IDLE: begin
                        if (start) begin
                            box_x0 <= xmin;
                            box_y0 <= ymin;
                            box_x1 <= xmax;
                            box_y1 <= ymax;
                            busy   <= 1'b1;
                            if (xmin > xmax || ymin > ymax) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state   <= S_LOAD;
                                ee_load <= 1'b1;
                                pix_x   <= xmin;
                                pix_y   <= ymin;
                            end
                        end
                    end

                    S_LOAD: begin
                        state     <= S_SCAN;
                        pix_valid <= 1'b1;
                        pix_last  <= (box_x0 == box_x1) && (box_y0 == box_y1);
                    end

                    S_SCAN: begin
                        // Bounds are tested before incrementing so a box
                        // touching the all-ones coordinate never wraps.
                        if (pix_ready) begin
                            if (pix_x < box_x1) begin
                                pix_x     <= x_inc;
                                ee_step_x <= 1'b1;
                                pix_last  <= (x_inc == box_x1) && (pix_y == box_y1);
                            end else if (pix_y < box_y1) begin
                                pix_x       <= box_x0;
                                pix_y       <= y_inc;
                                ee_step_row <= 1'b1;
                                pix_last    <= (box_x0 == box_x1) && (y_inc == box_y1);
                            end else begin
                                state     <= S_DONE;
                                pix_valid <= 1'b0;
                                pix_last  <= 1'b0;
                                done      <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    strobe_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({ee_load, ee_step_x, ee_step_row}));

endmodule

// File: tb/tb_raster_scan_sequencer.sv
// Directed bench for raster_scan_sequencer: box walks, backpressure, edge
// coordinates, config gating, abort and mid-scan reset.
module tb_raster_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_wr;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       start;
    logic       abort;
    logic       pix_ready;
    logic       pix_valid;
    logic [7:0] pix_x;
    logic [7:0] pix_y;
    logic       pix_last;
    logic       ee_load;
    logic       ee_step_x;
    logic       ee_step_row;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    raster_scan_sequencer #(.COORD_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .start       (start),
        .abort       (abort),
        .pix_ready   (pix_ready),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_last    (pix_last),
        .ee_load     (ee_load),
        .ee_step_x   (ee_step_x),
        .ee_step_row (ee_step_row),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // {pix_valid, ee_load, ee_step_x, ee_step_row, busy, done}
    function automatic logic [5:0] ctl();
        return {pix_valid, ee_load, ee_step_x, ee_step_row, busy, done};
    endfunction

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_wr   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_wr   = 1'b0;
    endtask

    task automatic set_box(input logic [7:0] x0, y0, x1, y1);
        cfg_write(2'd0, x0);
        cfg_write(2'd1, y0);
        cfg_write(2'd2, x1);
        cfg_write(2'd3, y1);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in the LOAD cycle with pix_ready held high; walks the whole box.
    task automatic expect_scan(input string tag, input int x0, y0, x1, y1);
        logic [7:0]  ex, ey;
        logic        sx, sr, lst;
        logic [22:0] exp_pix;
        chk({tag, "_load"}, 32'(ctl()), 32'(6'b010010));
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                tick();
                ex  = 8'(x);
                ey  = 8'(y);
                sx  = (x != x0);
                sr  = (x == x0) && (y != y0);
                lst = (x == x1) && (y == y1);
                exp_pix = {1'b1, 1'b0, sx, sr, 1'b1, 1'b0, lst, ex, ey};
                chk({tag, "_pix"}, 32'({ctl(), pix_last, pix_x, pix_y}), 32'(exp_pix));
            end
        end
        tick();
        chk({tag, "_done"}, 32'(ctl()), 32'(6'b000011));
        tick();
        chk({tag, "_idle"}, 32'(ctl()), 32'(6'b000000));
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_wr    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_data  = 8'd0;
        start     = 1'b0;
        abort     = 1'b0;
        pix_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        chk("reset_out", 32'({ctl(), pix_last, pix_x, pix_y}), 32'(0));
        rst_n = 1'b1;
        tick();

        // Basic 2x2 walk
        set_box(8'd2, 8'd5, 8'd3, 8'd6);
        do_start();
        expect_scan("box2x2", 2, 5, 3, 6);

        // Single pixel; a config write in the start cycle must not affect it
        set_box(8'd7, 8'd9, 8'd7, 8'd9);
        cfg_wr   = 1'b1;
        cfg_addr = 2'd2;
        cfg_data = 8'd8;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cfg_wr   = 1'b0;
        expect_scan("single", 7, 9, 7, 9);
        do_start();
        expect_scan("newxmax", 7, 9, 8, 9);

        // Empty box
        set_box(8'd10, 8'd0, 8'd4, 8'd0);
        do_start();
        chk("empty_done", 32'(ctl()), 32'(6'b000011));
        tick();
        chk("empty_idle", 32'(ctl()), 32'(6'b000000));

        // Backpressure at (0,0)
        set_box(8'd0, 8'd0, 8'd1, 8'd0);
        pix_ready = 1'b0;
        do_start();
        chk("bp_load", 32'(ctl()), 32'(6'b010010));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold", 32'({ctl(), pix_last, pix_x, pix_y}), 32'({6'b100010, 1'b0, 8'd0, 8'd0}));
        end
        pix_ready = 1'b1;
        tick();
        chk("bp_next", 32'({ctl(), pix_last, pix_x, pix_y}), 32'({6'b101010, 1'b1, 8'd1, 8'd0}));
        tick();
        chk("bp_done", 32'(ctl()), 32'(6'b000011));
        tick();

        // Top edge of coordinate space; write during scan is dropped
        set_box(8'd254, 8'd255, 8'd255, 8'd255);
        do_start();
        cfg_wr   = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = 8'd0;
        expect_scan("edge", 254, 255, 255, 255);
        cfg_wr = 1'b0;
        do_start();
        expect_scan("edge2", 254, 255, 255, 255);

        // Abort on third pixel, same cycle as a handshake
        set_box(8'd0, 8'd0, 8'd3, 8'd3);
        do_start();
        tick();
        tick();
        tick();
        chk("ab_third", 32'({ctl(), pix_x, pix_y}), 32'({6'b101010, 8'd2, 8'd0}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_cut", 32'(ctl()), 32'(6'b000000));
        tick();
        chk("ab_nodone", 32'(ctl()), 32'(6'b000000));
        do_start();
        expect_scan("full4x4", 0, 0, 3, 3);

        // Reset mid-scan clears outputs and config
        do_start();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("rst_mid", 32'({ctl(), pix_last, pix_x, pix_y}), 32'(0));
        rst_n = 1'b1;
        do_start();
        expect_scan("post_rst", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
